// File: rtl/control_sequencer.sv
// control_sequencer: fetch/execute T-state controller for the 8-bit bus
// datapath. Steps through T0..T4 per opcode and decodes every bus, load
// and ALU strobe from the current step, the opcode and the registered
// ALU flags. It also idles while RAM is being loaded and parks after HLT.
module control_sequencer #(
  parameter int OPC_W = 4,
  parameter int TS_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             program_mode,
  input  logic [OPC_W-1:0] opcode,
  input  logic             flag_c,
  input  logic             flag_z,
  output logic             pc_en,
  output logic             pc_up,
  output logic             pc_ld,
  output logic             mar_ld,
  output logic             ram_rd,
  output logic             ram_wr,
  output logic             ir_ld,
  output logic             ir_en,
  output logic             a_ld,
  output logic             a_en,
  output logic             b_ld,
  output logic             alu_en,
  output logic             alu_sub,
  output logic             flag_ld,
  output logic             out_ld,
  output logic             halted,
  output logic [TS_W-1:0]  tstate
);

  // State codes double as the tstate debug value, so they are fixed here.
  typedef enum logic [2:0] {
    S_T0   = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_PROG = 3'd6,
    S_HALT = 3'd7
  } state_t;

  localparam logic [OPC_W-1:0] OP_NOP = OPC_W'(4'h0);
  localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(4'h1);
  localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(4'h2);
  localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(4'h3);
  localparam logic [OPC_W-1:0] OP_STA = OPC_W'(4'h4);
  localparam logic [OPC_W-1:0] OP_LDI = OPC_W'(4'h5);
  localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(4'h6);
  localparam logic [OPC_W-1:0] OP_JC  = OPC_W'(4'h7);
  localparam logic [OPC_W-1:0] OP_JZ  = OPC_W'(4'h8);
  localparam logic [OPC_W-1:0] OP_OUT = OPC_W'(4'hE);
  localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(4'hF);

  state_t state_reg;
  state_t state_next;

  // State register; reset wins over everything, including HALT.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= program_mode ? S_PROG : S_T0;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and strobe decode; every strobe defaults low.
  always_comb begin
    state_next = S_T0;
    pc_en      = 1'b0;
    pc_up      = 1'b0;
    pc_ld      = 1'b0;
    mar_ld     = 1'b0;
    ram_rd     = 1'b0;
    ram_wr     = 1'b0;
    ir_ld      = 1'b0;
    ir_en      = 1'b0;
    a_ld       = 1'b0;
    a_en       = 1'b0;
    b_ld       = 1'b0;
    alu_en     = 1'b0;
    alu_sub    = 1'b0;
    flag_ld    = 1'b0;
    out_ld     = 1'b0;
    halted     = 1'b0;

    case (state_reg)
      S_PROG: begin
        state_next = S_T0;
      end

      S_T0: begin
        pc_en      = 1'b1;
        mar_ld     = 1'b1;
        state_next = S_T1;
      end

      S_T1: begin
        ram_rd     = 1'b1;
        ir_ld      = 1'b1;
        pc_up      = 1'b1;
        state_next = S_T2;
      end

      S_T2: begin
        state_next = S_T0;
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            ir_en      = 1'b1;
            mar_ld     = 1'b1;
            state_next = S_T3;
          end
          OP_LDI: begin
            ir_en = 1'b1;
            a_ld  = 1'b1;
          end
          OP_JMP: begin
            ir_en = 1'b1;
            pc_ld = 1'b1;
          end
          OP_JC: begin
            ir_en = flag_c;
            pc_ld = flag_c;
          end
          OP_JZ: begin
            ir_en = flag_z;
            pc_ld = flag_z;
          end
          OP_OUT: begin
            a_en   = 1'b1;
            out_ld = 1'b1;
          end
          OP_HLT: begin
            state_next = S_HALT;
          end
          default: begin
            // NOP and the unassigned opcodes fall straight back to fetch.
            state_next = S_T0;
          end
        endcase
      end

      S_T3: begin
        state_next = S_T0;
        case (opcode)
          OP_LDA: begin
            ram_rd = 1'b1;
            a_ld   = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ram_rd     = 1'b1;
            b_ld       = 1'b1;
            state_next = S_T4;
          end
          OP_STA: begin
            a_en   = 1'b1;
            ram_wr = 1'b1;
          end
          default: begin
            state_next = S_T0;
          end
        endcase
      end

      S_T4: begin
        state_next = S_T0;
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          alu_en  = 1'b1;
          a_ld    = 1'b1;
          flag_ld = 1'b1;
          alu_sub = (opcode == OP_SUB);
        end
      end

      S_HALT: begin
        halted     = 1'b1;
        state_next = S_HALT;
      end

      default: begin
        state_next = S_T0;
      end
    endcase

    // Program mode aborts whatever is in flight; this cycle's strobes stand.
    if (program_mode) begin
      state_next = S_PROG;
    end
  end

  // NOP is decoded by the default arm above; name kept for readability.
  logic unused_nop;
  assign unused_nop = (opcode == OP_NOP);

  assign tstate = TS_W'(state_reg);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: walks each opcode through its
// T-states and compares tstate, halted and the full strobe vector each cycle.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       program_mode;
  logic [3:0] opcode;
  logic       flag_c;
  logic       flag_z;
  logic       pc_en, pc_up, pc_ld, mar_ld, ram_rd, ram_wr, ir_ld, ir_en;
  logic       a_ld, a_en, b_ld, alu_en, alu_sub, flag_ld, out_ld, halted;
  logic [2:0] tstate;

  int checks   = 0;
  int failures = 0;

  // Strobe vector bit positions
  localparam logic [14:0] PC_EN   = 15'h4000;
  localparam logic [14:0] PC_UP   = 15'h2000;
  localparam logic [14:0] PC_LD   = 15'h1000;
  localparam logic [14:0] MAR_LD  = 15'h0800;
  localparam logic [14:0] RAM_RD  = 15'h0400;
  localparam logic [14:0] RAM_WR  = 15'h0200;
  localparam logic [14:0] IR_LD   = 15'h0100;
  localparam logic [14:0] IR_EN   = 15'h0080;
  localparam logic [14:0] A_LD    = 15'h0040;
  localparam logic [14:0] A_EN    = 15'h0020;
  localparam logic [14:0] B_LD    = 15'h0010;
  localparam logic [14:0] ALU_EN  = 15'h0008;
  localparam logic [14:0] ALU_SUB = 15'h0004;
  localparam logic [14:0] FLAG_LD = 15'h0002;
  localparam logic [14:0] OUT_LD  = 15'h0001;
  localparam logic [14:0] NONE    = 15'h0000;
  localparam logic [14:0] FETCH0  = PC_EN | MAR_LD;
  localparam logic [14:0] FETCH1  = RAM_RD | IR_LD | PC_UP;

  control_sequencer #(.OPC_W(4), .TS_W(3)) dut (
    .clk(clk), .rst(rst), .program_mode(program_mode), .opcode(opcode),
    .flag_c(flag_c), .flag_z(flag_z),
    .pc_en(pc_en), .pc_up(pc_up), .pc_ld(pc_ld), .mar_ld(mar_ld),
    .ram_rd(ram_rd), .ram_wr(ram_wr), .ir_ld(ir_ld), .ir_en(ir_en),
    .a_ld(a_ld), .a_en(a_en), .b_ld(b_ld), .alu_en(alu_en),
    .alu_sub(alu_sub), .flag_ld(flag_ld), .out_ld(out_ld),
    .halted(halted), .tstate(tstate)
  );

  always #5 clk = ~clk;

  logic [14:0] strobes;
  assign strobes = {pc_en, pc_up, pc_ld, mar_ld, ram_rd, ram_wr, ir_ld, ir_en,
                    a_ld, a_en, b_ld, alu_en, alu_sub, flag_ld, out_ld};

  // Advance one clock; outputs are sampled 2 time units after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [2:0] exp_ts,
                     input logic [14:0] exp_st, input logic exp_h);
    logic bus_ok;
    logic ram_ok;
    bus_ok = ($countones({pc_en, ram_rd, ir_en, a_en, alu_en}) <= 1);
    ram_ok = !(ram_rd && ram_wr);
    checks++;
    assert (tstate === exp_ts) else begin
      failures++;
      $error("FAIL %s tstate got=%0d exp=%0d", tag, tstate, exp_ts);
    end
    checks++;
    assert (strobes === exp_st) else begin
      failures++;
      $error("FAIL %s strobes got=%h exp=%h", tag, strobes, exp_st);
    end
    checks++;
    assert (halted === exp_h) else begin
      failures++;
      $error("FAIL %s halted got=%b exp=%b", tag, halted, exp_h);
    end
    checks++;
    assert (bus_ok === 1'b1) else begin
      failures++;
      $error("FAIL %s bus_onehot got=%b exp=1", tag, bus_ok);
    end
    checks++;
    assert (ram_ok === 1'b1) else begin
      failures++;
      $error("FAIL %s ram_rd_wr got=%b exp=1", tag, ram_ok);
    end
    $display("cycle %s ts=%0d strobes=%h halted=%b", tag, tstate, strobes, halted);
  endtask

  initial begin
    rst = 1'b1; program_mode = 1'b0; opcode = 4'h0; flag_c = 1'b0; flag_z = 1'b0;
    tick();
    tick();
    rst = 1'b0; #1;
    chk("reset_t0", 3'd0, FETCH0, 1'b0);

    // LDA
    opcode = 4'h1;
    tick(); chk("lda_t1", 3'd1, FETCH1, 1'b0);
    tick(); chk("lda_t2", 3'd2, IR_EN | MAR_LD, 1'b0);
    tick(); chk("lda_t3", 3'd3, RAM_RD | A_LD, 1'b0);
    tick(); chk("lda_end", 3'd0, FETCH0, 1'b0);

    // SUB
    opcode = 4'h3;
    tick(); chk("sub_t1", 3'd1, FETCH1, 1'b0);
    tick(); chk("sub_t2", 3'd2, IR_EN | MAR_LD, 1'b0);
    tick(); chk("sub_t3", 3'd3, RAM_RD | B_LD, 1'b0);
    tick(); chk("sub_t4", 3'd4, ALU_EN | A_LD | FLAG_LD | ALU_SUB, 1'b0);
    tick(); chk("sub_end", 3'd0, FETCH0, 1'b0);

    // ADD
    opcode = 4'h2;
    tick(); tick(); tick();
    chk("add_t3", 3'd3, RAM_RD | B_LD, 1'b0);
    tick(); chk("add_t4", 3'd4, ALU_EN | A_LD | FLAG_LD, 1'b0);
    tick(); chk("add_end", 3'd0, FETCH0, 1'b0);

    // STA
    opcode = 4'h4;
    tick(); tick(); chk("sta_t2", 3'd2, IR_EN | MAR_LD, 1'b0);
    tick(); chk("sta_t3", 3'd3, A_EN | RAM_WR, 1'b0);
    tick(); chk("sta_end", 3'd0, FETCH0, 1'b0);

    // LDI
    opcode = 4'h5;
    tick(); tick(); chk("ldi_t2", 3'd2, IR_EN | A_LD, 1'b0);
    tick(); chk("ldi_end", 3'd0, FETCH0, 1'b0);

    // JMP
    opcode = 4'h6;
    tick(); tick(); chk("jmp_t2", 3'd2, IR_EN | PC_LD, 1'b0);
    tick(); chk("jmp_end", 3'd0, FETCH0, 1'b0);

    // JZ not taken (carry set must not matter)
    opcode = 4'h8; flag_z = 1'b0; flag_c = 1'b1;
    tick(); tick(); chk("jz0_t2", 3'd2, NONE, 1'b0);
    tick(); chk("jz0_end", 3'd0, FETCH0, 1'b0);

    // JZ taken
    flag_z = 1'b1; flag_c = 1'b0;
    tick(); tick(); chk("jz1_t2", 3'd2, IR_EN | PC_LD, 1'b0);
    tick();

    // JC not taken with zero set, then taken
    opcode = 4'h7; flag_c = 1'b0; flag_z = 1'b1;
    tick(); tick(); chk("jc0_t2", 3'd2, NONE, 1'b0);
    tick();
    flag_c = 1'b1; flag_z = 1'b0;
    tick(); tick(); chk("jc1_t2", 3'd2, IR_EN | PC_LD, 1'b0);
    tick(); chk("jc1_end", 3'd0, FETCH0, 1'b0);
    flag_c = 1'b0;

    // OUT
    opcode = 4'hE;
    tick(); tick(); chk("out_t2", 3'd2, A_EN | OUT_LD, 1'b0);
    tick();

    // Unassigned opcode behaves as NOP
    opcode = 4'hA;
    tick(); tick(); chk("nopA_t2", 3'd2, NONE, 1'b0);
    tick(); chk("nopA_end", 3'd0, FETCH0, 1'b0);

    // HLT: HALT from the 4th cycle, held for 20 cycles
    opcode = 4'hF;
    tick(); tick(); chk("hlt_t2", 3'd2, NONE, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick(); chk("halt_hold", 3'd7, NONE, 1'b1);
    end
    // rst leaves HALT
    rst = 1'b1;
    tick(); rst = 1'b0; #1;
    chk("halt_rst", 3'd0, FETCH0, 1'b0);

    // Halt again, then leave via program_mode
    tick(); tick(); tick(); chk("hlt2_halt", 3'd7, NONE, 1'b1);
    program_mode = 1'b1;
    tick(); chk("halt_to_prog", 3'd6, NONE, 1'b0);
    program_mode = 1'b0;
    tick(); chk("prog_exit", 3'd0, FETCH0, 1'b0);

    // Program mode raised during T3 of ADD
    opcode = 4'h2;
    tick(); tick(); tick();
    program_mode = 1'b1; #1;
    chk("add_t3_pm", 3'd3, RAM_RD | B_LD, 1'b0);
    tick(); chk("pm_prog", 3'd6, NONE, 1'b0);
    tick(); chk("pm_prog_hold", 3'd6, NONE, 1'b0);
    program_mode = 1'b0;
    tick(); chk("pm_exit_t0", 3'd0, FETCH0, 1'b0);
    tick(); chk("pm_exit_t1", 3'd1, FETCH1, 1'b0);

    // Reset mid-instruction with program_mode high lands in PROG
    tick();
    rst = 1'b1; program_mode = 1'b1;
    tick(); rst = 1'b0; #1;
    chk("rst_pm_prog", 3'd6, NONE, 1'b0);
    program_mode = 1'b0;
    tick(); chk("rst_pm_exit", 3'd0, FETCH0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Microcode-style fetch/execute controller for the 8-bit bus datapath.
- Sequences the program counter (pc_en/pc_up/pc_ld), the MAR, RAM, IR, A/B registers, the ALU and the output register through T-states per 4-bit opcode.
- Handles conditional jumps from ALU flags, halt, and program-mode (RAM loading) hold-off.
- Sits between the instruction register and every load/enable strobe in the datapath.

Parameters:
- OPC_W, 4, opcode width (IR upper nibble).
- TS_W, 3, width of tstate debug output.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- program_mode  input  1  1 = RAM being loaded externally; sequencer idles
- opcode  input  OPC_W  IR upper nibble, valid from T2 onward
- flag_c  input  1  registered ALU carry flag
- flag_z  input  1  registered ALU zero flag
- pc_en  output  1  PC drives bus
- pc_up  output  1  PC increment
- pc_ld  output  1  PC load from bus
- mar_ld  output  1  MAR load from bus
- ram_rd  output  1  RAM drives bus
- ram_wr  output  1  RAM write from bus
- ir_ld  output  1  IR load from bus
- ir_en  output  1  IR low nibble drives bus (zero-extended)
- a_ld, a_en, b_ld  output  1 each  A load, A drive bus, B load
- alu_en  output  1  ALU result drives bus
- alu_sub  output  1  ALU subtract select
- flag_ld  output  1  latch ALU flags
- out_ld  output  1  output register load
- halted  output  1  in HALT state
- tstate  output  TS_W  current step: 0..4 = T0..T4, 6 = PROG, 7 = HALT

Behaviour:
- States: PROG, T0..T4, HALT. All strobes decode combinationally from state + opcode + flags. Strobes not listed for a state are 0.
- Reset (rst=1 at edge): next state T0, or PROG if program_mode=1. Reset overrides every other condition, including HALT. Reset mid-instruction discards the instruction.
- PROG: all strobes 0. Exit to T0 on the first edge with program_mode=0.
- Any state with program_mode=1 at the edge goes to PROG, aborting the current instruction. Strobes of the current cycle still assert.
- T0: pc_en, mar_ld. Next T1.
- T1: ram_rd, ir_ld, pc_up. Next T2.
- PC wrap 0xFF->0x00 is owned by the PC. The sequencer always asserts pc_up in T1.
- T2..T4 by opcode. "End" means the next state is T0.
  - 0x0 NOP: T2 no strobes; end.
  - 0x1 LDA: T2 ir_en,mar_ld; T3 ram_rd,a_ld; end.
  - 0x2 ADD: T2 ir_en,mar_ld; T3 ram_rd,b_ld; T4 alu_en,a_ld,flag_ld; end.
  - 0x3 SUB: same as ADD, with alu_sub=1 in T4.
  - 0x4 STA: T2 ir_en,mar_ld; T3 a_en,ram_wr; end.
  - 0x5 LDI: T2 ir_en,a_ld; end.
  - 0x6 JMP: T2 ir_en,pc_ld; end.
  - 0x7 JC: T2 ir_en,pc_ld only if flag_c=1 (sampled in T2); end.
  - 0x8 JZ: T2 ir_en,pc_ld only if flag_z=1 (sampled in T2); end.
  - 0xE OUT: T2 a_en,out_ld; end.
  - 0xF HLT: T2 no strobes; next HALT.
  - 0x9..0xD: treated as NOP.
- Instruction lengths: NOP/LDI/JMP/JC/JZ/OUT = 3 cycles; LDA/STA = 4 cycles; ADD/SUB = 5 cycles.
- HALT: all strobes 0, halted=1. Leave only via rst, or via program_mode=1 (then PROG).
- Invariant: at most one of pc_en, ram_rd, ir_en, a_en, alu_en is 1 in any cycle (single bus driver).
- Invariant: ram_rd and ram_wr are never both 1.

Test Plan:
- Reset: assert rst with program_mode=0 -> tstate=0, halted=0; next cycle pc_en=mar_ld=1, all other strobes 0.
- LDA 0x1: opcode=0x1 -> strobes T0 {pc_en,mar_ld}, T1 {ram_rd,ir_ld,pc_up}, T2 {ir_en,mar_ld}, T3 {ram_rd,a_ld}; tstate=0 on the 5th cycle.
- SUB: opcode=0x3 -> T4 shows alu_en=a_ld=flag_ld=alu_sub=1; total 5 cycles; bus-driver one-hot check holds every cycle.
- JZ: opcode=0x8 with flag_z=0 -> no pc_ld in T2. Repeat with flag_z=1 -> pc_ld=ir_en=1 in T2. JC with flag_c=1 -> pc_ld=1.
- HLT: opcode=0xF -> HALT at cycle 4, halted=1 and tstate=7 held for 20 cycles, no strobes; rst -> T0.
- Program mode: raise program_mode during T3 of ADD -> tstate=6 next cycle, all strobes 0; drop it -> T0 next edge, fetch restarts.
